mlp_result_collector: RTL and testbench

Downstream consumer of the multi-MLP dot-product wrapper. It captures the per-column `t_mlp_out` sums and their per-column valids, which may arrive on different cycles, and assembles them into complete rows. Each row is buffered in a small row FIFO, then rounded, shifted, saturated and serialised onto a ready/valid stream, one column per beat. It also gives the upstream sequencer a stall hint and an overflow error flag.

---
 rtl/mlp_collect_pkg.sv | 35 +++
 rtl/mlp_row_fifo.sv | 53 +++++
 rtl/mlp_result_collector.sv | 183 ++++++++++++++++++
 tb/tb_mlp_result_collector.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_collect_pkg.sv
// Shared types and the output quantiser for the MLP result collectors.
// t_mlp_out mirrors the wrapper's 48-bit signed column sum.
package mlp_collect_pkg;

   localparam int unsigned MLP_OUT_W    = 48;
   localparam int unsigned MLP_MAX_COLS = 4;

   typedef logic signed [MLP_OUT_W-1:0] t_mlp_out;
   typedef t_mlp_out [MLP_MAX_COLS-1:0] t_mlp_row;

   typedef enum logic {StIdle, StSend} t_out_state;

   // Round-half-up arithmetic shift, then saturate to a signed width-bit range.
   // One guard bit keeps the rounding add from wrapping at the 48-bit extremes.
   function automatic t_mlp_out quantise(input t_mlp_out x, input int unsigned shift,
                                         input int unsigned width);
      logic signed [MLP_OUT_W:0] one;
      logic signed [MLP_OUT_W:0] ext;
      logic signed [MLP_OUT_W:0] half;
      logic signed [MLP_OUT_W:0] q;
      logic signed [MLP_OUT_W:0] hi;
      logic signed [MLP_OUT_W:0] lo;
      one  = 1;
      ext  = {x[MLP_OUT_W-1], x};
      half = '0;
      if (shift > 0) half = one <<< (shift - 1);
      q  = (ext + half) >>> shift;
      hi = (one <<< (width - 1)) - one;
      lo = -(one <<< (width - 1));
      if (q > hi) q = hi;
      else if (q < lo) q = lo;
      return q[MLP_OUT_W-1:0];
   endfunction

endpackage

// File: rtl/mlp_row_fifo.sv
// Synchronous row FIFO with async active-low reset and synchronous clear.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module mlp_row_fifo
   import mlp_collect_pkg::*;
#(
   parameter int unsigned WIDTH = MLP_MAX_COLS * MLP_OUT_W,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             wr_en;
   logic             rd_en;

   assign level = wptr_q - rptr_q;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign rdata = mem[rptr_q[AW-1:0]];
   assign rd_en = pop && !empty && !clear;
   assign wr_en = push && (!full || rd_en) && !clear;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_q[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clear) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (rd_en) rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/mlp_result_collector.sv
// Gathers per-column MLP sums into rows, queues them and streams quantised
// words one column per beat on a ready/valid interface.
module mlp_result_collector
   import mlp_collect_pkg::*;
#(
   parameter int unsigned MAX_COLS   = 4,
   parameter int unsigned OUT_WIDTH  = 16,
   parameter int unsigned SHIFT      = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  t_mlp_out                      din [MAX_COLS],
   input  logic [MAX_COLS-1:0]           din_valid,
   input  logic                          clear,
   output logic [OUT_WIDTH-1:0]          dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic                          dout_first,
   output logic                          dout_last,
   output logic                          stall,
   output logic                          overflow_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RW = MAX_COLS * MLP_OUT_W;
   localparam int unsigned IW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

   // Capture side
   t_mlp_out            hold_q [MAX_COLS];
   logic [MAX_COLS-1:0] hvld_q;
   logic [MAX_COLS-1:0] hvld_d;
   logic                ovf_q;
   logic                ovf_hit;
   logic                push;
   logic [RW-1:0]       row_in;

   // FIFO
   logic [RW-1:0]       rdata;
   logic                full;
   logic                empty;
   logic [LW-1:0]       level;
   logic [LW-1:0]       level_nxt;
   logic                stall_q;

   // Output stage
   t_out_state          state_q;
   t_out_state          state_d;
   logic [IW-1:0]       idx_q;
   logic [IW-1:0]       idx_nxt;
   logic [RW-1:0]       row_q;
   logic [RW-1:0]       src_row;
   logic [OUT_WIDTH-1:0] dout_q;
   logic                valid_q;
   logic                first_q;
   logic                last_q;
   logic                hs;
   logic                pop;
   logic                adv;
   t_mlp_out            qword;

   always_comb begin
      row_in = '0;
      for (int c = 0; c < int'(MAX_COLS); c++) row_in[c*MLP_OUT_W +: MLP_OUT_W] = hold_q[c];
   end

   // A push frees every column, so captures that coincide with it are always taken.
   assign push    = (&hvld_q) && (!full || pop) && !clear;
   assign hvld_d  = push ? din_valid : (hvld_q | din_valid);
   assign ovf_hit = !push && |(din_valid & hvld_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < int'(MAX_COLS); c++) hold_q[c] <= '0;
         hvld_q <= '0;
         ovf_q  <= 1'b0;
      end else if (clear) begin
         hvld_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         for (int c = 0; c < int'(MAX_COLS); c++) begin
            if (din_valid[c] && (push || !hvld_q[c])) hold_q[c] <= din[c];
         end
         hvld_q <= hvld_d;
         if (ovf_hit) ovf_q <= 1'b1;
      end
   end

   mlp_row_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .push    (push),
      .wdata   (row_in),
      .pop     (pop),
      .rdata   (rdata),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // stall tracks the level the FIFO will hold after this edge
   assign level_nxt = clear ? '0 : level + LW'(push) - LW'(pop);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      adv     = 1'b0;
      hs      = valid_q && dout_ready;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (hs && (idx_q == IW'(MAX_COLS - 1))) begin
               if (!empty) pop = 1'b1;
               else state_d = StIdle;
            end else if (hs) begin
               adv = 1'b1;
            end
         end
      endcase
      if (clear) begin
         state_d = StIdle;
         pop     = 1'b0;
         adv     = 1'b0;
      end
   end

   always_comb begin
      src_row = pop ? rdata : row_q;
      idx_nxt = pop ? '0 : idx_q + 1'b1;
      qword   = quantise(src_row[int'(idx_nxt)*MLP_OUT_W +: MLP_OUT_W], SHIFT, OUT_WIDTH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         row_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stall_q <= (level_nxt >= LW'(FIFO_DEPTH - 1));
         if (clear) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
         end else if (pop || adv) begin
            if (pop) row_q <= rdata;
            idx_q   <= idx_nxt;
            dout_q  <= qword[OUT_WIDTH-1:0];
            valid_q <= 1'b1;
            first_q <= pop;
            last_q  <= (idx_nxt == IW'(MAX_COLS - 1));
         end else if (hs) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

   assign dout         = dout_q;
   assign dout_valid   = valid_q;
   assign dout_first   = first_q;
   assign dout_last    = last_q;
   assign stall        = stall_q;
   assign overflow_err = ovf_q;
   assign fifo_level   = level;

endmodule

// File: tb/tb_mlp_result_collector.sv
// Directed bench for mlp_result_collector: latency, quantisation, saturation,
// backpressure, overflow, push collision, clear and asynchronous reset.
module tb_mlp_result_collector;
   import mlp_collect_pkg::*;

   localparam int unsigned MAX_COLS   = 4;
   localparam int unsigned OUT_WIDTH  = 16;
   localparam int unsigned SHIFT      = 4;
   localparam int unsigned FIFO_DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 clear = 1'b0;
   logic                 dout_ready = 1'b0;
   t_mlp_out             din [MAX_COLS];
   logic [MAX_COLS-1:0]  din_valid;
   logic [OUT_WIDTH-1:0] dout;
   logic                 dout_valid;
   logic                 dout_first;
   logic                 dout_last;
   logic                 stall;
   logic                 overflow_err;
   logic [3:0]           fifo_level;

   int passes = 0;
   int fails  = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mlp_result_collector #(
      .MAX_COLS   (MAX_COLS),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT      (SHIFT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .din          (din),
      .din_valid    (din_valid),
      .clear        (clear),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout_first   (dout_first),
      .dout_last    (dout_last),
      .stall        (stall),
      .overflow_err (overflow_err),
      .fifo_level   (fifo_level)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic signed [63:0] a,
                        input logic signed [63:0] b, input logic signed [63:0] c,
                        input logic signed [63:0] d);
      din[0]    = a[47:0];
      din[1]    = b[47:0];
      din[2]    = c[47:0];
      din[3]    = d[47:0];
      din_valid = v;
   endtask

   task automatic word(input string tag, input logic signed [63:0] w, input logic f,
                       input logic l);
      chk({tag, " valid"}, dout_valid, 1);
      chk({tag, " dout"}, $signed(dout), w);
      chk({tag, " first"}, dout_first, f);
      chk({tag, " last"}, dout_last, l);
      tick();
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " dout"}, dout, 0);
      chk({tag, " valid"}, dout_valid, 0);
      chk({tag, " first"}, dout_first, 0);
      chk({tag, " last"}, dout_last, 0);
      chk({tag, " stall"}, stall, 0);
      chk({tag, " ovf"}, overflow_err, 0);
      chk({tag, " level"}, fifo_level, 0);
   endtask

   initial begin
      drive(4'h0, 0, 0, 0, 0);
      #1;
      all_zero("reset");
      tick();
      tick();
      reset_n    = 1'b1;
      dout_ready = 1'b1;

      // Aligned row: 256, 24, -24, 0 -> 16, 2, -1, 0
      drive(4'hf, 256, 24, -24, 0);
      tick();
      din_valid = '0;
      chk("aligned n+1 valid", dout_valid, 0);
      tick();
      chk("aligned n+2 level", fifo_level, 1);
      chk("aligned n+2 valid", dout_valid, 0);
      tick();
      word("aligned w0", 16, 1, 0);
      word("aligned w1", 2, 0, 0);
      word("aligned w2", -1, 0, 0);
      word("aligned w3", 0, 0, 1);
      chk("aligned idle", dout_valid, 0);
      chk("aligned level", fifo_level, 0);

      // Staggered columns with saturation, first beat in cycle 6
      drive(4'b0001, 1000000, 1000000, -1000000, -1000000);
      tick();
      din_valid = 4'b0010;
      tick();
      din_valid = 4'b0100;
      tick();
      din_valid = 4'b1000;
      tick();
      din_valid = '0;
      tick();
      chk("stagger c5 valid", dout_valid, 0);
      tick();
      word("stagger w0", 32767, 1, 0);
      word("stagger w1", 32767, 0, 0);
      word("stagger w2", -32768, 0, 0);
      word("stagger w3", -32768, 0, 1);
      chk("stagger idle", dout_valid, 0);

      // Push collision on column 2
      drive(4'hf, 160, 320, 480, 640);
      tick();
      drive(4'b0100, 0, 0, 800, 0);
      tick();
      drive(4'b1011, 16, 32, 0, 64);
      tick();
      din_valid = '0;
      word("coll A0", 10, 1, 0);
      word("coll A1", 20, 0, 0);
      word("coll A2", 30, 0, 0);
      word("coll A3", 40, 0, 1);
      word("coll B0", 1, 1, 0);
      word("coll B1", 2, 0, 0);
      word("coll B2", 50, 0, 0);
      word("coll B3", 4, 0, 1);
      chk("coll idle", dout_valid, 0);
      chk("coll ovf", overflow_err, 0);

      // Backpressure: ten aligned rows, word value = row*4 + col
      dout_ready = 1'b0;
      for (int r = 0; r < 10; r++) begin
         drive(4'hf, (r*4)*16, (r*4+1)*16, (r*4+2)*16, (r*4+3)*16);
         tick();
         if (r == 7) begin
            chk("bp level 6", fifo_level, 6);
            chk("bp stall at 6", stall, 0);
         end
         if (r == 8) begin
            chk("bp level 7", fifo_level, 7);
            chk("bp stall at 7", stall, 1);
         end
      end
      chk("bp full level", fifo_level, 8);
      drive(4'b0001, 9999*16, 0, 0, 0);
      tick();
      din_valid = '0;
      chk("bp ovf", overflow_err, 1);
      chk("bp level held", fifo_level, 8);
      chk("bp stall held", stall, 1);
      for (int i = 0; i < 9; i++) tick();
      chk("bp hold valid", dout_valid, 1);
      chk("bp hold dout", dout, 0);
      chk("bp hold first", dout_first, 1);
      dout_ready = 1'b1;
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 4; c++) begin
            word($sformatf("drain r%0d c%0d", r, c), r*4 + c, c == 0, c == 3);
         end
      end
      chk("drain idle", dout_valid, 0);
      chk("drain level", fifo_level, 0);
      chk("drain stall", stall, 0);

      // Clear mid-SEND at word 1
      drive(4'hf, 16, 32, 48, 64);
      tick();
      drive(4'hf, 160, 160, 160, 160);
      tick();
      din_valid = '0;
      tick();
      chk("clr w0", $signed(dout), 1);
      drive(4'b0001, 1600, 0, 0, 0);
      tick();
      din_valid = '0;
      chk("clr w1", $signed(dout), 2);
      chk("clr ovf before", overflow_err, 1);
      clear = 1'b1;
      drive(4'b0010, 0, 1600, 0, 0);
      tick();
      clear     = 1'b0;
      din_valid = '0;
      chk("clr valid", dout_valid, 0);
      chk("clr level", fifo_level, 0);
      chk("clr ovf", overflow_err, 0);
      chk("clr stall", stall, 0);
      drive(4'b1110, 0, 80, 96, 112);
      tick();
      din_valid = '0;
      tick();
      tick();
      tick();
      chk("clr partial level", fifo_level, 0);
      chk("clr partial valid", dout_valid, 0);
      drive(4'b0001, 64, 0, 0, 0);
      tick();
      din_valid = '0;
      tick();
      tick();
      word("clr new w0", 4, 1, 0);
      word("clr new w1", 5, 0, 0);
      word("clr new w2", 6, 0, 0);
      word("clr new w3", 7, 0, 1);

      // Asynchronous reset mid-row
      dout_ready = 1'b0;
      drive(4'hf, 160, 160, 160, 160);
      tick();
      din_valid = '0;
      tick();
      tick();
      chk("rst pre valid", dout_valid, 1);
      drive(4'b0001, 320, 0, 0, 0);
      tick();
      tick();
      din_valid = '0;
      chk("rst pre ovf", overflow_err, 1);
      #3;
      reset_n = 1'b0;
      #1;
      all_zero("async rst");
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      chk("post rst valid", dout_valid, 0);
      chk("post rst level", fifo_level, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
